alu_in_cmd_driver: RTL

//  Synthesizable, emulation-friendly driver for the alu_in valid/ready bus.

---
 rtl/alu_in_cmd_driver_if.sv | 32 +++
 rtl/alu_in_cmd_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_in_cmd_driver_if.sv
// alu_in valid/ready bus between the command driver and the ALU.
// Master drives alu_rst/valid/op/a/b; slave drives ready.
interface alu_in_cmd_driver_if #(
    parameter int ALU_IN_OP_WIDTH = 8
) ();

    logic                       alu_rst;
    logic                       valid;
    logic                       ready;
    logic [2:0]                 op;
    logic [ALU_IN_OP_WIDTH-1:0] a;
    logic [ALU_IN_OP_WIDTH-1:0] b;

    modport master (
        output alu_rst,
        output valid,
        output op,
        output a,
        output b,
        input  ready
    );

    modport slave (
        input  alu_rst,
        input  valid,
        input  op,
        input  a,
        input  b,
        output ready
    );

endinterface

// File: rtl/alu_in_cmd_driver.sv
// Command FIFO plus replay FSM driving the alu_in bus (transfers, ALU reset pulses,
// idle gaps, optional back-to-back issue, ready watchdog).
// Ports: clk/rst, cmd_* push side, cfg_b2b, alu_in bus, busy/fifo_level/counters.
module alu_in_cmd_driver #(
    parameter int ALU_IN_OP_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_WIDTH       = 4,
    parameter int RST_CYCLES      = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_kind,
    input  logic [2:0]                    cmd_op,
    input  logic [ALU_IN_OP_WIDTH-1:0]    cmd_a,
    input  logic [ALU_IN_OP_WIDTH-1:0]    cmd_b,
    input  logic [GAP_WIDTH-1:0]          cmd_gap,
    input  logic                          cfg_b2b,
    alu_in_cmd_driver_if.master           alu_in,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   xfer_cnt,
    output logic                          timeout_pulse,
    output logic [7:0]                    timeout_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef struct packed {
        logic                       kind;
        logic [2:0]                 op;
        logic [ALU_IN_OP_WIDTH-1:0] a;
        logic [ALU_IN_OP_WIDTH-1:0] b;
        logic [GAP_WIDTH-1:0]       gap;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        DRIVE,
        GAP,
        RST_PULSE
    } state_t;

    state_t                     state;
    cmd_t                       mem [FIFO_DEPTH];
    cmd_t                       head;
    cmd_t                       cur;
    cmd_t                       in_cmd;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       b2b_go;
    logic                       valid_q;
    logic                       alu_rst_q;
    logic [2:0]                 op_q;
    logic [ALU_IN_OP_WIDTH-1:0] a_q;
    logic [ALU_IN_OP_WIDTH-1:0] b_q;
    logic [WW-1:0]              wait_cnt;
    logic [GAP_WIDTH-1:0]       gap_cnt;
    logic [RW-1:0]              rst_cnt;

    always_comb begin
        in_cmd    = '{kind: cmd_kind, op: cmd_op, a: cmd_a,
                      b: cmd_b, gap: cmd_gap};
        full      = (fifo_level == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
        empty     = (fifo_level == '0);
        cmd_ready = !full;
        push      = cmd_valid && !full;
        head      = mem[rd_ptr];
        // Chain the next transfer with no bubble only when nothing
        // (gap, reset pulse, stall) would have to sit between them.
        b2b_go    = cfg_b2b && (cur.gap == '0) && !empty
                    && !head.kind && alu_in.ready;
        pop       = ((state == IDLE) && !empty)
                    || ((state == DRIVE) && b2b_go);
    end

    assign busy           = (state != IDLE) || !empty;
    assign alu_in.valid   = valid_q;
    assign alu_in.alu_rst = alu_rst_q;
    assign alu_in.op      = op_q;
    assign alu_in.a       = a_q;
    assign alu_in.b       = b_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur           <= '0;
            valid_q       <= 1'b0;
            alu_rst_q     <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            rst_cnt       <= '0;
            xfer_cnt      <= '0;
            timeout_pulse <= 1'b0;
            timeout_cnt   <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        cur <= head;
                        if (head.kind) begin
                            alu_rst_q <= 1'b1;
                            rst_cnt   <= RW'(RST_CYCLES);
                            state     <= RST_PULSE;
                        end else if (alu_in.ready) begin
                            valid_q <= 1'b1;
                            op_q    <= head.op;
                            a_q     <= head.a;
                            b_q     <= head.b;
                            state   <= DRIVE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (alu_in.ready) begin
                        valid_q <= 1'b1;
                        op_q    <= cur.op;
                        a_q     <= cur.a;
                        b_q     <= cur.b;
                        state   <= DRIVE;
                    end else if ((TIMEOUT_CYCLES != 0)
                                 && (wait_cnt == WW'(TIMEOUT_CYCLES - 1))) begin
                        timeout_pulse <= 1'b1;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        if (cur.gap != '0) begin
                            gap_cnt <= cur.gap;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DRIVE: begin
                    xfer_cnt <= xfer_cnt + 16'd1;
                    if (b2b_go) begin
                        cur  <= head;
                        op_q <= head.op;
                        a_q  <= head.a;
                        b_q  <= head.b;
                    end else begin
                        valid_q <= 1'b0;
                        op_q    <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        if (cur.gap != '0) begin
                            gap_cnt <= cur.gap;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt <= GAP_WIDTH'(1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                RST_PULSE: begin
                    if (rst_cnt <= RW'(1)) begin
                        alu_rst_q <= 1'b0;
                        if (cur.gap != '0) begin
                            gap_cnt <= cur.gap;
                            state   <= GAP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
